// File: rtl/pipe_ctrl_unit_pkg.sv
// ------------------------------------------------------------------------
// pipe_ctrl_unit_pkg : opcodes, control-bit indices and select encodings
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_unit_pkg;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_andi  = 6'b001100;
   localparam logic [5:0] c_op_ori   = 6'b001101;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;

   // Bit positions inside the 12-bit control word
   localparam int c_sig_aluop2     = 11;
   localparam int c_sig_invbranch  = 10;
   localparam int c_sig_zeroextend = 9;
   localparam int c_sig_regdst     = 8;
   localparam int c_sig_alusrcb    = 7;
   localparam int c_sig_memtoreg   = 6;
   localparam int c_sig_writereg   = 5;
   localparam int c_sig_memwrite   = 4;
   localparam int c_sig_branch     = 3;
   localparam int c_sig_aluop1     = 2;
   localparam int c_sig_aluop0     = 1;
   localparam int c_sig_jump       = 0;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   function automatic logic op_uses_rs(input logic [5:0] op);
      case (op)
         c_op_rtype, c_op_lw, c_op_sw, c_op_beq, c_op_bne,
         c_op_addi, c_op_andi, c_op_ori: op_uses_rs = 1'b1;
         default:                        op_uses_rs = 1'b0;
      endcase
   endfunction

   function automatic logic op_uses_rt(input logic [5:0] op);
      case (op)
         c_op_rtype, c_op_sw, c_op_beq, c_op_bne: op_uses_rt = 1'b1;
         default:                                 op_uses_rt = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// ------------------------------------------------------------------------
// pipe_ctrl_unit_ctrl_decode : combinational opcode to control-word decoder
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_unit_ctrl_decode
   import pipe_ctrl_unit_pkg::*;
#(
   parameter int OP_W  = 6,
   parameter int SIG_W = 12
) (
   input  logic [OP_W-1:0]  op,
   output logic [SIG_W-1:0] sig
);

   always_comb begin
      sig = '0;
      case (op)
         c_op_rtype: begin
            sig[c_sig_regdst]   = 1'b1;
            sig[c_sig_writereg] = 1'b1;
            sig[c_sig_aluop1]   = 1'b1;
         end
         c_op_lw: begin
            sig[c_sig_alusrcb]  = 1'b1;
            sig[c_sig_memtoreg] = 1'b1;
            sig[c_sig_writereg] = 1'b1;
         end
         c_op_sw: begin
            sig[c_sig_alusrcb]  = 1'b1;
            sig[c_sig_memwrite] = 1'b1;
         end
         c_op_beq: begin
            sig[c_sig_branch] = 1'b1;
            sig[c_sig_aluop0] = 1'b1;
         end
         c_op_bne: begin
            sig[c_sig_branch]    = 1'b1;
            sig[c_sig_invbranch] = 1'b1;
            sig[c_sig_aluop0]    = 1'b1;
         end
         c_op_j: begin
            sig[c_sig_jump] = 1'b1;
         end
         c_op_addi: begin
            sig[c_sig_alusrcb]  = 1'b1;
            sig[c_sig_writereg] = 1'b1;
         end
         // Logical immediates zero-extend and select the ALU's AND/OR ops
         c_op_andi: begin
            sig[c_sig_aluop2]     = 1'b1;
            sig[c_sig_zeroextend] = 1'b1;
            sig[c_sig_alusrcb]    = 1'b1;
            sig[c_sig_writereg]   = 1'b1;
         end
         c_op_ori: begin
            sig[c_sig_aluop2]     = 1'b1;
            sig[c_sig_zeroextend] = 1'b1;
            sig[c_sig_alusrcb]    = 1'b1;
            sig[c_sig_writereg]   = 1'b1;
            sig[c_sig_aluop0]     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// ------------------------------------------------------------------------
// pipe_ctrl_unit : pipelined control, hazard and PC-select unit (FORWARD_EN)
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_unit
   import pipe_ctrl_unit_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int OP_W   = 6,
   parameter int SIG_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   op,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   input  logic              ex_zero,
   output logic [SIG_W-1:0]  ex_sig,
   output logic [SIG_W-1:0]  mem_sig,
   output logic [SIG_W-1:0]  wb_sig,
   output logic [REG_AW-1:0] ex_wreg,
   output logic [REG_AW-1:0] mem_wreg,
   output logic [REG_AW-1:0] wb_wreg,
   output logic              stall,
   output logic              flush_if,
   output logic [1:0]        pc_sel,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic [SIG_W-1:0]  w_id_sig;
   logic [REG_AW-1:0] w_id_wreg;
   logic              w_use_rs;
   logic              w_use_rt;
   logic              w_rs_haz;
   logic              w_rt_haz;
   logic              w_br_taken;
   logic              w_bubble;

   logic [SIG_W-1:0]  r_ex_sig;
   logic [SIG_W-1:0]  r_mem_sig;
   logic [SIG_W-1:0]  r_wb_sig;
   logic [REG_AW-1:0] r_ex_wreg;
   logic [REG_AW-1:0] r_mem_wreg;
   logic [REG_AW-1:0] r_wb_wreg;

   pipe_ctrl_unit_ctrl_decode #(
      .OP_W  (OP_W),
      .SIG_W (SIG_W)
   ) u_ctrl_decode (
      .op  (op),
      .sig (w_id_sig)
   );

   assign w_use_rs  = op_uses_rs(op);
   assign w_use_rt  = op_uses_rt(op);
   assign w_id_wreg = w_id_sig[c_sig_writereg]
                    ? (w_id_sig[c_sig_regdst] ? rd : rt)
                    : '0;

   assign w_br_taken = r_ex_sig[c_sig_branch] & (ex_zero ^ r_ex_sig[c_sig_invbranch]);

   // Stage tags are already zero for non-writers, so a nonzero source match means a live producer
`ifdef FORWARD_EN
   logic w_ex_is_load;
   assign w_ex_is_load = r_ex_sig[c_sig_memtoreg] && (r_ex_wreg != '0);
   assign w_rs_haz = w_use_rs && (rs != '0) && w_ex_is_load && (rs == r_ex_wreg);
   assign w_rt_haz = w_use_rt && (rt != '0) && w_ex_is_load && (rt == r_ex_wreg);
`else
   assign w_rs_haz = w_use_rs && (rs != '0) && ((rs == r_ex_wreg) || (rs == r_mem_wreg));
   assign w_rt_haz = w_use_rt && (rt != '0) && ((rt == r_ex_wreg) || (rt == r_mem_wreg));
`endif

   always_comb begin
      stall    = 1'b0;
      flush_if = 1'b0;
      pc_sel   = PC_SEQ;
      if (w_br_taken) begin
         pc_sel   = PC_BR;
         flush_if = 1'b1;
      end else if (w_rs_haz || w_rt_haz) begin
         stall = 1'b1;
      end else if (w_id_sig[c_sig_jump]) begin
         pc_sel   = PC_JMP;
         flush_if = 1'b1;
      end
   end

   assign w_bubble = w_br_taken | stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_sig   <= '0;
         r_mem_sig  <= '0;
         r_wb_sig   <= '0;
         r_ex_wreg  <= '0;
         r_mem_wreg <= '0;
         r_wb_wreg  <= '0;
      end else begin
         r_wb_sig   <= r_mem_sig;
         r_wb_wreg  <= r_mem_wreg;
         r_mem_sig  <= r_ex_sig;
         r_mem_wreg <= r_ex_wreg;
         if (w_bubble) begin
            r_ex_sig  <= '0;
            r_ex_wreg <= '0;
         end else begin
            r_ex_sig  <= w_id_sig;
            r_ex_wreg <= w_id_wreg;
         end
      end
   end

`ifdef FORWARD_EN
   logic [REG_AW-1:0] r_ex_rs;
   logic [REG_AW-1:0] r_ex_rt;

   // Unused sources are captured as r0 so they can never select a bypass
   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         r_ex_rs <= '0;
         r_ex_rt <= '0;
      end else begin
         r_ex_rs <= w_use_rs ? rs : '0;
         r_ex_rt <= w_use_rt ? rt : '0;
      end
   end

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (r_mem_sig[c_sig_writereg] && (r_mem_wreg != '0) && (r_mem_wreg == r_ex_rs))
         fwd_a = FWD_MEM;
      else if (r_wb_sig[c_sig_writereg] && (r_wb_wreg != '0) && (r_wb_wreg == r_ex_rs))
         fwd_a = FWD_WB;
      if (r_mem_sig[c_sig_writereg] && (r_mem_wreg != '0) && (r_mem_wreg == r_ex_rt))
         fwd_b = FWD_MEM;
      else if (r_wb_sig[c_sig_writereg] && (r_wb_wreg != '0) && (r_wb_wreg == r_ex_rt))
         fwd_b = FWD_WB;
   end
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

   assign ex_sig   = r_ex_sig;
   assign mem_sig  = r_mem_sig;
   assign wb_sig   = r_wb_sig;
   assign ex_wreg  = r_ex_wreg;
   assign mem_wreg = r_mem_wreg;
   assign wb_wreg  = r_wb_wreg;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ------------------------------------------------------------------------
// tb_pipe_ctrl_unit : directed table plus randomized model check (FORWARD_EN aware)
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl_unit;

   localparam int OP_R    = 'h00;
   localparam int OP_J    = 'h02;
   localparam int OP_BEQ  = 'h04;
   localparam int OP_BNE  = 'h05;
   localparam int OP_ADDI = 'h08;
   localparam int OP_ANDI = 'h0C;
   localparam int OP_ORI  = 'h0D;
   localparam int OP_LW   = 'h23;
   localparam int OP_SW   = 'h2B;
   localparam int OP_NOP  = 'h3F;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic        ex_zero;
   logic [11:0] ex_sig, mem_sig, wb_sig;
   logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
   logic        stall, flush_if;
   logic [1:0]  pc_sel, fwd_a, fwd_b;

   always #5 clk = ~clk;

   pipe_ctrl_unit dut (
      .clk(clk), .rst(rst), .op(op), .rs(rs), .rt(rt), .rd(rd), .ex_zero(ex_zero),
      .ex_sig(ex_sig), .mem_sig(mem_sig), .wb_sig(wb_sig),
      .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
      .stall(stall), .flush_if(flush_if), .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   // Instruction-level pipeline model: each stage holds an instruction record
   typedef struct {
      int op;
      int dest;
      int s1;
      int s2;
   } rec_t;

   typedef struct {
      int r, o, a, b, c, z;
      int st, fl, pc, fa, fb;
      int cx, ex, exw, cmw;
   } vec_t;

   rec_t m_ex, m_mem, m_wb, bubble;
   vec_t vq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cur_r, cur_op, cur_rs, cur_rt, cur_rd, cur_z;
   int   e_stall, e_flush, e_taken, e_pc, e_fa, e_fb;

   function automatic int word_of(int o);
      case (o)
         OP_R:    return 'h124;
         OP_LW:   return 'h0E0;
         OP_SW:   return 'h090;
         OP_BEQ:  return 'h00A;
         OP_BNE:  return 'h40A;
         OP_J:    return 'h001;
         OP_ADDI: return 'h0A0;
         OP_ANDI: return 'hAA0;
         OP_ORI:  return 'hAA2;
         default: return 0;
      endcase
   endfunction

   function automatic rec_t make_rec(int o, int a, int b, int c);
      rec_t r;
      r.op   = o;
      r.dest = (o == OP_R) ? c :
               (o == OP_LW || o == OP_ADDI || o == OP_ANDI || o == OP_ORI) ? b : 0;
      r.s1   = (o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_BNE ||
                o == OP_ADDI || o == OP_ANDI || o == OP_ORI) ? a : 0;
      r.s2   = (o == OP_R || o == OP_SW || o == OP_BEQ || o == OP_BNE) ? b : 0;
      return r;
   endfunction

   function automatic int fwd_for(int src);
      if (!FWD || src == 0) return 0;
      if (src == m_mem.dest) return 2;
      if (src == m_wb.dest)  return 1;
      return 0;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic predict();
      rec_t id;
      int   srcs[2];
      int   haz;
      id      = make_rec(cur_op, cur_rs, cur_rt, cur_rd);
      e_taken = ((m_ex.op == OP_BEQ && cur_z != 0) || (m_ex.op == OP_BNE && cur_z == 0)) ? 1 : 0;
      srcs[0] = id.s1;
      srcs[1] = id.s2;
      haz = 0;
      for (int i = 0; i < 2; i++) begin
         if (srcs[i] != 0) begin
            if (FWD) begin
               if (m_ex.op == OP_LW && srcs[i] == m_ex.dest) haz = 1;
            end else begin
               if (srcs[i] == m_ex.dest || srcs[i] == m_mem.dest) haz = 1;
            end
         end
      end
      e_stall = (e_taken == 0 && haz != 0) ? 1 : 0;
      e_pc    = (e_taken != 0) ? 1 : (cur_op == OP_J && e_stall == 0) ? 2 : 0;
      e_flush = (e_pc != 0) ? 1 : 0;
      e_fa    = fwd_for(m_ex.s1);
      e_fb    = fwd_for(m_ex.s2);
   endtask

   task automatic apply(int r, int o, int a, int b, int c, int z);
      cur_r = r; cur_op = o; cur_rs = a; cur_rt = b; cur_rd = c; cur_z = z;
      rst = r[0]; op = o[5:0]; rs = a[4:0]; rt = b[4:0]; rd = c[4:0]; ex_zero = z[0];
      @(negedge clk);
      predict();
   endtask

   task automatic advance();
      rec_t id;
      id = make_rec(cur_op, cur_rs, cur_rt, cur_rd);
      @(posedge clk);
      if (cur_r != 0) begin
         m_ex = bubble; m_mem = bubble; m_wb = bubble;
      end else begin
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = (e_taken != 0 || e_stall != 0) ? bubble : id;
      end
      #1;
   endtask

   task automatic add(int r, int o, int a, int b, int c, int z, int st, int fl, int pc,
                      int fa, int fb, int cx, int ex, int exw, int cmw);
      vec_t v;
      v = '{r, o, a, b, c, z, st, fl, pc, fa, fb, cx, ex, exw, cmw};
      vq.push_back(v);
   endtask

   task automatic nop_row();
      add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      int         lo, la, lb, lc, lr;
      int         prev_stall, prev_flush;
      int         ops[10];
      bubble = '{OP_NOP, 0, 0, 0};
      m_ex = bubble; m_mem = bubble; m_wb = bubble;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_NOP};

      repeat (2) begin
         apply(1, OP_NOP, 0, 0, 0, 0);
         advance();
      end

      // LW r2 ; ADD r3,r2,r4
      add(0, OP_LW, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 1);
      add(0, OP_R,  2, 4, 3, 0, 1, 0, 0, 0, 0, 1, 'h0E0, 2, 0);
      if (FWD) begin
         add(0, OP_R,   2, 4, 3, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
         add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h124, 3, 0);
      end else begin
         add(0, OP_R,   2, 4, 3, 0, 1, 0, 0, 0, 0, 1, 'h000, 0, 0);
         add(0, OP_R,   2, 4, 3, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
         add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h124, 3, 0);
      end
      nop_row(); nop_row();
      // ADDI r1 ; SUB r5,r1,r1
      add(0, OP_ADDI, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_R,    1, 1, 5, 0, FWD ? 0 : 1, 0, 0, 0, 0, 1, 'h0A0, 1, 0);
      if (FWD) begin
         add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 'h124, 5, 0);
      end else begin
         add(0, OP_R,   1, 1, 5, 0, 1, 0, 0, 0, 0, 1, 'h000, 0, 0);
         add(0, OP_R,   1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
         add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h124, 5, 0);
      end
      nop_row(); nop_row();
      // Branches and jumps
      add(0, OP_BEQ, 6, 7, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_J,   0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 'h00A, 0, 0);
      add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_BNE, 6, 7, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_NOP, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h40A, 0, 0);
      add(0, OP_J,   0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h001, 0, 0);
      add(0, OP_BNE, 6, 7, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_NOP, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'h40A, 0, 0);
      nop_row();
      // r0 producers and unknown opcode
      add(0, OP_ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(0, OP_R,    0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 'h0A0, 0, 0);
      add(0, OP_NOP,  3, 3, 3, 0, 0, 0, 0, 0, 0, 1, 'h124, 8, 0);
      nop_row();
      // Reset mid-stream with a load-use pending
      add(0, OP_LW, 0, 9, 0,  0, 0, 0, 0, 0, 0, 1, 'h000, 0, 0);
      add(1, OP_R,  9, 9, 10, 0, 1, 0, 0, 0, 0, 1, 'h0E0, 9, 0);
      add(1, OP_R,  9, 9, 10, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 1);
      add(0, OP_R,  9, 9, 10, 0, 0, 0, 0, 0, 0, 1, 'h000, 0, 1);
      add(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h124, 10, 0);

      foreach (vq[i]) begin
         apply(vq[i].r, vq[i].o, vq[i].a, vq[i].b, vq[i].c, vq[i].z);
         check($sformatf("vec%0d stall", i),    32'(stall),    32'(vq[i].st));
         check($sformatf("vec%0d flush_if", i), 32'(flush_if), 32'(vq[i].fl));
         check($sformatf("vec%0d pc_sel", i),   32'(pc_sel),   32'(vq[i].pc));
         check($sformatf("vec%0d fwd_a", i),    32'(fwd_a),    32'(vq[i].fa));
         check($sformatf("vec%0d fwd_b", i),    32'(fwd_b),    32'(vq[i].fb));
         if (vq[i].cx != 0) begin
            check($sformatf("vec%0d ex_sig", i),  32'(ex_sig),  32'(vq[i].ex));
            check($sformatf("vec%0d ex_wreg", i), 32'(ex_wreg), 32'(vq[i].exw));
         end
         if (vq[i].cmw != 0) begin
            check($sformatf("vec%0d mem_sig", i),  32'(mem_sig),  32'(0));
            check($sformatf("vec%0d wb_sig", i),   32'(wb_sig),   32'(0));
            check($sformatf("vec%0d mem_wreg", i), 32'(mem_wreg), 32'(0));
            check($sformatf("vec%0d wb_wreg", i),  32'(wb_wreg),  32'(0));
         end
         advance();
      end

      prev_stall = 0;
      prev_flush = 0;
      lo = OP_NOP; la = 0; lb = 0; lc = 0;
      for (int k = 0; k < 600; k++) begin
         lr = ($urandom_range(0, 59) == 0) ? 1 : 0;
         if (prev_stall == 0) begin
            if (prev_flush != 0) begin
               lo = OP_NOP; la = 0; lb = 0; lc = 0;
            end else begin
               lo = ops[$urandom_range(0, 9)];
               la = int'($urandom_range(0, 3));
               lb = int'($urandom_range(0, 3));
               lc = int'($urandom_range(0, 3));
            end
         end
         apply(lr, lo, la, lb, lc, int'($urandom_range(0, 1)));
         check($sformatf("rnd%0d stall", k),    32'(stall),    32'(e_stall));
         check($sformatf("rnd%0d flush_if", k), 32'(flush_if), 32'(e_flush));
         check($sformatf("rnd%0d pc_sel", k),   32'(pc_sel),   32'(e_pc));
         check($sformatf("rnd%0d fwd_a", k),    32'(fwd_a),    32'(e_fa));
         check($sformatf("rnd%0d fwd_b", k),    32'(fwd_b),    32'(e_fb));
         check($sformatf("rnd%0d ex_sig", k),   32'(ex_sig),   32'(word_of(m_ex.op)));
         check($sformatf("rnd%0d mem_sig", k),  32'(mem_sig),  32'(word_of(m_mem.op)));
         check($sformatf("rnd%0d wb_sig", k),   32'(wb_sig),   32'(word_of(m_wb.op)));
         check($sformatf("rnd%0d ex_wreg", k),  32'(ex_wreg),  32'(m_ex.dest));
         check($sformatf("rnd%0d mem_wreg", k), 32'(mem_wreg), 32'(m_mem.dest));
         check($sformatf("rnd%0d wb_wreg", k),  32'(wb_wreg),  32'(m_wb.dest));
         prev_stall = (e_stall != 0 && lr == 0) ? 1 : 0;
         prev_flush = (e_flush != 0 && lr == 0) ? 1 : 0;
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
